upd78xx_intc: RTL and testbench
===============================

# upd78xx_intc

Parametrised interrupt controller for the uPD78xx CPU cores: a configurable number of maskable sources plus one NMI. It synchronises the sources, latches requests per channel in edge or level mode and arbitrates by fixed priority. It then presents one request and its 16-bit vector to the core through a request/acknowledge handshake. It sits between the SoC peripherals (timer, serial, external INT pins) and the core's interrupt-entry microcode, which owns the IE flag.

## Interface
- NUM_IRQ, 4, number of maskable sources (1..8); channel 0 has the highest priority.
- SYNC_STAGES, 2, synchroniser flops per input (≥1).
- VEC_NMI, 16'h0004, vector presented for NMI.
- VEC_BASE, 16'h0008, vector of channel 0.
- VEC_STRIDE, 8, vector spacing; channel n vector = VEC_BASE + n*VEC_STRIDE, truncated to 16 bits.
- CLK  in  1  system clock.
- RESETB  in  1  reset, asynchronous, active-low.
- CE  in  1  tick enable; the core drives it from CP2_NEGEDGE; all state advances only when CE=1.
- NMI  in  1  non-maskable request, falling-edge triggered, asynchronous.
- IRQ  in  NUM_IRQ  maskable requests, asynchronous, active-high.
- MODE  in  NUM_IRQ  per channel: 1 = rising-edge latched, 0 = level.
- MASK  in  NUM_IRQ  per channel: 1 = masked (still latches, never requested).
- IE  in  1  core global interrupt enable; gates maskable channels only.
- CLR  in  NUM_IRQ  one-tick software clear of a pending edge latch.
- INT_ACK  in  1  core acknowledge, held high until INT_REQ falls.
- INT_REQ  out  1  interrupt request to core.
- INT_NMI  out  1  qualifies INT_REQ as NMI.
- INT_VEC  out  16  vector of the request being presented.
- PEND  out  NUM_IRQ  raw pending state (edge latches; for level channels, the synchronised level).

## Operation
- Reset: sync chains clear to 0. NMI chain presets to 1 so no false falling edge occurs. Pending latches, nmi_pend, INT_REQ and INT_NMI clear to 0. INT_VEC = 16'h0000. FSM enters IDLE.
- Edge channel: pending sets on a tick where the synced input goes 0→1. It clears on CLR or on acknowledge of that channel. If set and clear land on the same tick, set wins.
- Level channel: pending = synced input. CLR and acknowledge have no effect on it.
- nmi_pend sets on a synced 1→0 of NMI and clears only on NMI acknowledge; set wins over clear.
- Eligibility: nmi_pend always; channel n if PEND[n] & ~MASK[n] & IE.
- Arbitration: NMI first, then the lowest eligible index.
- FSM states:
  - IDLE: on a tick with any eligible source, latch the winner's id and vector, set INT_REQ, and go to REQ.
  - REQ: the winner is re-arbitrated every tick. If NMI becomes pending while a maskable channel is presented, switch id/vector to NMI and set INT_NMI. The NMI preemption applies on the same tick. If the presented maskable channel loses eligibility (level drops, MASK, IE=0, CLR) and nothing else is eligible, drop INT_REQ and return to IDLE. If it loses eligibility while another channel is eligible, present that channel. On INT_ACK=1: clear the presented edge latch or nmi_pend, drop INT_REQ, and go to ACKED. INT_VEC holds its value.
  - ACKED: wait for INT_ACK=0, then go to IDLE. New requests only latch pending during this state.
- INT_VEC and INT_NMI change only on the ticks where INT_REQ rises or the presented id is switched in REQ. They are never changed on the tick INT_ACK is sampled.

## Timing
- Input edge to pending: SYNC_STAGES+1 ticks. Pending to INT_REQ: 1 tick. Total with SYNC_STAGES=2 and CE=1 every clock: INT_REQ rises 4 clocks after the IRQ edge.
- Ack to INT_REQ low: 1 tick. Minimum gap before the next request: 2 ticks (ACKED, then IDLE).
- An edge pulse shorter than one tick period may be lost. Level channels must stay asserted until acknowledged.
- RESETB low mid-handshake forces all outputs to their reset values immediately, without waiting for CLK.

## Test plan
- Reset: hold RESETB=0 with NMI=0 and IRQ=all ones. Require INT_REQ=0, INT_VEC=0 and PEND=0. After release, with MODE=1, no request is raised because no edge occurred.
- Edge channel (CE=1, IE=1, MODE[2]=1): raise IRQ[2]. Require INT_REQ high 4 clocks later with INT_VEC=16'h0018. Assert INT_ACK. Require INT_REQ low next clock and PEND[2]=0.
- Priority and preemption: pend IRQ[1] and IRQ[3] together, giving INT_VEC=16'h0010. Then drop NMI before the ack. Require INT_NMI=1 and INT_VEC=16'h0004. After the NMI ack, the next request is 16'h0010.
- Masking and withdrawal: present level channel 0, then deassert IRQ[0] before the ack. Require INT_REQ low within 3 ticks. Set MASK[1] with IRQ[1] pending: require PEND[1]=1 and INT_REQ=0. Clear the mask: INT_REQ rises with 16'h0010.
- Simultaneous set and clear: pulse CLR[2] on the same tick a new edge on channel 2 is detected. Require PEND[2]=1.
- Async reset: assert RESETB in REQ state between clock edges. Require INT_REQ=0 before the next CLK edge. After release, the FSM is in IDLE.

Source files
------------

// File: rtl/upd78xx_intc.sv
// Interrupt controller for uPD78xx cores: synchronised NMI plus NUM_IRQ maskable
// channels, edge/level latching, fixed-priority arbitration, req/ack handshake.
module upd78xx_intc #(
    parameter int          NUM_IRQ     = 4,
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] VEC_NMI     = 16'h0004,
    parameter logic [15:0] VEC_BASE    = 16'h0008,
    parameter int          VEC_STRIDE  = 8
) (
    input  logic               CLK,
    input  logic               RESETB,
    input  logic               CE,
    input  logic               NMI,
    input  logic [NUM_IRQ-1:0] IRQ,
    input  logic [NUM_IRQ-1:0] MODE,
    input  logic [NUM_IRQ-1:0] MASK,
    input  logic               IE,
    input  logic [NUM_IRQ-1:0] CLR,
    input  logic               INT_ACK,
    output logic               INT_REQ,
    output logic               INT_NMI,
    output logic [15:0]        INT_VEC,
    output logic [NUM_IRQ-1:0] PEND
);
    localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACKED} state_t;

    function automatic logic [15:0] chan_vec(input logic [ID_W-1:0] id);
        logic [31:0] v;
        v = 32'(VEC_BASE) + 32'(id) * 32'(VEC_STRIDE);
        return v[15:0];
    endfunction

    logic [NUM_IRQ-1:0]     r_irq_sync [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] r_nmi_sync;
    logic [NUM_IRQ-1:0]     r_irq_prev;
    logic                   r_nmi_prev;
    logic [NUM_IRQ-1:0]     r_edge_pend;
    logic                   r_nmi_pend;
    state_t                 r_state;
    logic                   r_cur_nmi;
    logic [ID_W-1:0]        r_cur_id;

    logic [NUM_IRQ-1:0] w_irq_s;
    logic               w_nmi_s;
    logic [NUM_IRQ-1:0] w_irq_rise;
    logic               w_nmi_fall;
    logic               w_ack;
    logic [NUM_IRQ-1:0] w_ack_edge_clr;
    logic [NUM_IRQ-1:0] w_elig;
    logic               w_any;
    logic               w_win_nmi;
    logic [ID_W-1:0]    w_win_id;
    logic [15:0]        w_win_vec;
    logic               w_switch;

    // NMI chain presets high so reset release never looks like a falling edge.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_irq_sync[i] <= '0;
            r_nmi_sync <= '1;
            r_irq_prev <= '0;
            r_nmi_prev <= 1'b1;
        end else if (CE) begin
            r_irq_sync[0] <= IRQ;
            r_nmi_sync[0] <= NMI;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_irq_sync[i] <= r_irq_sync[i-1];
                r_nmi_sync[i] <= r_nmi_sync[i-1];
            end
            r_irq_prev <= w_irq_s;
            r_nmi_prev <= w_nmi_s;
        end
    end

    assign w_irq_s    = r_irq_sync[SYNC_STAGES-1];
    assign w_nmi_s    = r_nmi_sync[SYNC_STAGES-1];
    assign w_irq_rise = w_irq_s & ~r_irq_prev;
    assign w_nmi_fall = ~w_nmi_s & r_nmi_prev;
    assign w_ack      = CE && (r_state == S_REQ) && INT_ACK;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_ack_edge_clr = '0;
        for (int i = 0; i < NUM_IRQ; i++)
            w_ack_edge_clr[i] = w_ack && !r_cur_nmi && (r_cur_id == ID_W'(i));
    end

    // Set terms are OR-ed last so a same-tick set beats CLR or acknowledge.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            r_edge_pend <= '0;
            r_nmi_pend  <= 1'b0;
        end else if (CE) begin
            r_edge_pend <= MODE & (w_irq_rise | (r_edge_pend & ~CLR & ~w_ack_edge_clr));
            r_nmi_pend  <= w_nmi_fall | (r_nmi_pend & ~(w_ack & r_cur_nmi));
        end
    end

    assign PEND   = (MODE & r_edge_pend) | (~MODE & w_irq_s);
    assign w_elig = PEND & ~MASK & {NUM_IRQ{IE}};
    assign w_any  = r_nmi_pend | (|w_elig);

    always_comb begin
        w_win_nmi = r_nmi_pend;
        w_win_id  = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (w_elig[i]) w_win_id = ID_W'(i);
        w_win_vec = w_win_nmi ? VEC_NMI : chan_vec(w_win_id);
    end

    assign w_switch = (w_win_nmi != r_cur_nmi) || (!w_win_nmi && (w_win_id != r_cur_id));

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            r_state   <= S_IDLE;
            r_cur_nmi <= 1'b0;
            r_cur_id  <= '0;
            INT_REQ   <= 1'b0;
            INT_NMI   <= 1'b0;
            INT_VEC   <= 16'h0000;
        end else if (CE) begin
            case (r_state)
                S_IDLE: if (w_any) begin
                    r_cur_nmi <= w_win_nmi;
                    r_cur_id  <= w_win_id;
                    INT_NMI   <= w_win_nmi;
                    INT_VEC   <= w_win_vec;
                    INT_REQ   <= 1'b1;
                    r_state   <= S_REQ;
                end
                S_REQ: begin
                    // Acknowledge takes precedence; vector stays frozen for the core.
                    if (INT_ACK) begin
                        INT_REQ <= 1'b0;
                        r_state <= S_ACKED;
                    end else if (!w_any) begin
                        INT_REQ <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (w_switch) begin
                        r_cur_nmi <= w_win_nmi;
                        r_cur_id  <= w_win_id;
                        INT_NMI   <= w_win_nmi;
                        INT_VEC   <= w_win_vec;
                    end
                end
                S_ACKED: if (!INT_ACK) r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_upd78xx_intc.sv
// Directed bench for upd78xx_intc: vector table for level-channel arbitration
// plus hand sequences for edge timing, NMI preemption, masking and async reset.
module tb_upd78xx_intc;
    logic        CLK = 1'b0;
    logic        RESETB, CE, NMI, IE, INT_ACK;
    logic [3:0]  IRQ, MODE, MASK, CLR;
    logic        INT_REQ, INT_NMI;
    logic [15:0] INT_VEC;
    logic [3:0]  PEND;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]  irq;
        logic [3:0]  mask;
        logic        ie;
        logic        exp_req;
        logic [15:0] exp_vec;
        logic [3:0]  exp_pend;
    } vec_t;

    vec_t tbl [7];

    always #5 CLK = ~CLK;

    upd78xx_intc dut (
        .CLK(CLK), .RESETB(RESETB), .CE(CE), .NMI(NMI), .IRQ(IRQ), .MODE(MODE),
        .MASK(MASK), .IE(IE), .CLR(CLR), .INT_ACK(INT_ACK), .INT_REQ(INT_REQ),
        .INT_NMI(INT_NMI), .INT_VEC(INT_VEC), .PEND(PEND)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic ack_and_clear();
        INT_ACK = 1'b1;
        tick(1);
        INT_ACK = 1'b0;
        IRQ     = 4'b0000;
        tick(4);
    endtask

    initial begin
        tbl[0] = '{4'b0001, 4'b0000, 1'b1, 1'b1, 16'h0008, 4'b0001};
        tbl[1] = '{4'b1010, 4'b0000, 1'b1, 1'b1, 16'h0010, 4'b1010};
        tbl[2] = '{4'b1000, 4'b0000, 1'b1, 1'b1, 16'h0020, 4'b1000};
        tbl[3] = '{4'b0110, 4'b0010, 1'b1, 1'b1, 16'h0018, 4'b0110};
        tbl[4] = '{4'b1111, 4'b1111, 1'b1, 1'b0, 16'h0000, 4'b1111};
        tbl[5] = '{4'b0100, 4'b0000, 1'b0, 1'b0, 16'h0000, 4'b0100};
        tbl[6] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 16'h0000, 4'b0000};

        // Reset with every input in its active state.
        RESETB = 1'b0; CE = 1'b1; NMI = 1'b0; IRQ = 4'b1111; MODE = 4'b1111;
        MASK = 4'b0000; IE = 1'b1; CLR = 4'b0000; INT_ACK = 1'b0;
        tick(3);
        check("reset_req", 32'(INT_REQ), 32'd0);
        check("reset_vec", 32'(INT_VEC), 32'h0);
        check("reset_pend", 32'(PEND), 32'h0);
        NMI = 1'b1; IRQ = 4'b0000;
        tick(1);
        RESETB = 1'b1;
        tick(6);
        check("post_reset_no_req", 32'(INT_REQ), 32'd0);
        check("post_reset_pend", 32'(PEND), 32'h0);

        // Level-channel arbitration table.
        MODE = 4'b0000;
        for (int i = 0; i < 7; i++) begin
            IRQ = tbl[i].irq; MASK = tbl[i].mask; IE = tbl[i].ie;
            tick(5);
            check($sformatf("tbl%0d_req", i), 32'(INT_REQ), 32'(tbl[i].exp_req));
            check($sformatf("tbl%0d_pend", i), 32'(PEND), 32'(tbl[i].exp_pend));
            if (tbl[i].exp_req) begin
                check($sformatf("tbl%0d_vec", i), 32'(INT_VEC), 32'(tbl[i].exp_vec));
                check($sformatf("tbl%0d_nmi", i), 32'(INT_NMI), 32'd0);
                ack_and_clear();
            end else begin
                IRQ = 4'b0000;
                tick(4);
            end
        end
        MASK = 4'b0000; IE = 1'b1;

        // Edge channel 2: request four clocks after the IRQ edge.
        MODE = 4'b0100; IRQ = 4'b0100;
        tick(3);
        check("edge_req_early", 32'(INT_REQ), 32'd0);
        tick(1);
        check("edge_req", 32'(INT_REQ), 32'd1);
        check("edge_vec", 32'(INT_VEC), 32'h0018);
        INT_ACK = 1'b1;
        tick(1);
        check("edge_ack_req", 32'(INT_REQ), 32'd0);
        check("edge_ack_pend", 32'(PEND[2]), 32'd0);
        check("edge_ack_vec_hold", 32'(INT_VEC), 32'h0018);
        INT_ACK = 1'b0; IRQ = 4'b0000;
        tick(4);
        check("edge_no_rereq", 32'(INT_REQ), 32'd0);

        // Priority between edge channels 1 and 3, then NMI preemption.
        MODE = 4'b1010; IRQ = 4'b1010;
        tick(4);
        check("prio_req", 32'(INT_REQ), 32'd1);
        check("prio_vec", 32'(INT_VEC), 32'h0010);
        NMI = 1'b0;
        tick(3);
        check("nmi_not_yet", 32'(INT_NMI), 32'd0);
        tick(1);
        check("nmi_flag", 32'(INT_NMI), 32'd1);
        check("nmi_vec", 32'(INT_VEC), 32'h0004);
        check("nmi_req", 32'(INT_REQ), 32'd1);
        INT_ACK = 1'b1;
        tick(1);
        check("nmi_ack_req", 32'(INT_REQ), 32'd0);
        check("nmi_ack_vec_hold", 32'(INT_VEC), 32'h0004);
        INT_ACK = 1'b0; NMI = 1'b1;
        tick(2);
        check("after_nmi_req", 32'(INT_REQ), 32'd1);
        check("after_nmi_vec", 32'(INT_VEC), 32'h0010);
        check("after_nmi_flag", 32'(INT_NMI), 32'd0);
        INT_ACK = 1'b1;
        tick(1);
        INT_ACK = 1'b0;
        tick(2);
        check("ch3_vec", 32'(INT_VEC), 32'h0020);
        ack_and_clear();
        check("prio_done_pend", 32'(PEND), 32'h0);

        // Withdrawal of a presented level channel.
        MODE = 4'b0000; IRQ = 4'b0001;
        tick(3);
        check("lvl0_req", 32'(INT_REQ), 32'd1);
        check("lvl0_vec", 32'(INT_VEC), 32'h0008);
        IRQ = 4'b0000;
        for (int t = 0; t < 3 && INT_REQ; t++) tick(1);
        check("withdraw_req", 32'(INT_REQ), 32'd0);

        // Masked edge channel keeps pending but never requests.
        MODE = 4'b0010; MASK = 4'b0010; IRQ = 4'b0010;
        tick(5);
        check("mask_pend", 32'(PEND[1]), 32'd1);
        check("mask_req", 32'(INT_REQ), 32'd0);
        MASK = 4'b0000;
        tick(1);
        check("unmask_req", 32'(INT_REQ), 32'd1);
        check("unmask_vec", 32'(INT_VEC), 32'h0010);
        ack_and_clear();

        // CLR on the same tick as a new edge: the set must win.
        IE = 1'b0; MODE = 4'b0100; IRQ = 4'b0100;
        tick(2);
        CLR = 4'b0100;
        tick(1);
        CLR = 4'b0000;
        check("set_wins_pend", 32'(PEND[2]), 32'd1);
        CLR = 4'b0100;
        tick(1);
        CLR = 4'b0000;
        check("clr_alone_pend", 32'(PEND[2]), 32'd0);
        IRQ = 4'b0000; IE = 1'b1;
        tick(3);

        // Asynchronous reset in the middle of a presented request.
        MODE = 4'b0000; IRQ = 4'b1000;
        tick(3);
        check("areset_pre_req", 32'(INT_REQ), 32'd1);
        check("areset_pre_vec", 32'(INT_VEC), 32'h0020);
        #2 RESETB = 1'b0;
        #1;
        check("areset_req", 32'(INT_REQ), 32'd0);
        check("areset_vec", 32'(INT_VEC), 32'h0);
        check("areset_pend", 32'(PEND), 32'h0);
        IRQ = 4'b0000;
        @(negedge CLK);
        RESETB = 1'b1;
        tick(2);
        check("areset_idle_req", 32'(INT_REQ), 32'd0);
        IRQ = 4'b1000;
        tick(3);
        check("areset_idle_newreq", 32'(INT_REQ), 32'd1);
        check("areset_idle_vec", 32'(INT_VEC), 32'h0020);
        ack_and_clear();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
